// File: rtl/times_table_divider_if.sv
// times_table_divider_if: start/busy/done handshake and operand/result bus for
// the times-table divider.
//   master : drives start, dividend (2N), divisor (N); observes results
//   slave  : drives busy, done, quotient (2N), remainder (N), err
interface times_table_divider_if #(
    parameter int unsigned N = 3
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             err;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, err
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, err
    );
endinterface

// File: rtl/times_table_divider.sv
// times_table_divider: sequential restoring divider, one quotient bit per clock.
// Divides a 2N-bit product by an N-bit factor and returns quotient/remainder.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of times_table_divider_if
//            start/dividend/divisor in; busy/done/quotient/remainder/err out
// A division accepted at edge T raises done for the cycle after edge T+2N.
// Divide-by-zero skips CALC and raises done (with err) for the cycle after T.
module times_table_divider #(
    parameter int unsigned N = 3
) (
    input  logic clk,
    input  logic rst_n,
    times_table_divider_if.slave bus
);
    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    work_q;
    logic [N-1:0]    prem;
    logic [N-1:0]    dvs;
    logic [CW-1:0]   count;

    logic [RW-1:0]   shifted;
    logic            fits;
    logic [N-1:0]    prem_next;
    logic [W-1:0]    q_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder is always < divisor, so the restored value and the
    // difference both fit back into N bits.
    always_comb begin
        shifted   = {prem, work_q[W-1]};
        fits      = (shifted >= RW'(dvs));
        prem_next = fits ? N'(shifted - RW'(dvs)) : N'(shifted);
        q_next    = {work_q[W-2:0], fits};
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            work_q        <= '0;
            prem          <= '0;
            dvs           <= '0;
            count         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            dvs      <= bus.divisor;
                            work_q   <= bus.dividend;
                            prem     <= '0;
                            count    <= CW'(W - 1);
                            bus.err  <= 1'b0;
                            bus.busy <= 1'b1;
                            state    <= CALC;
                        end else begin
                            bus.err       <= 1'b1;
                            bus.quotient  <= '0;
                            bus.remainder <= '0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                CALC: begin
                    work_q <= q_next;
                    prem   <= prem_next;
                    count  <= count - CW'(1);
                    // Last step: publish the final quotient/remainder directly.
                    if (count == '0) begin
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.quotient  <= q_next;
                        bus.remainder <= prem_next;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_times_table_divider.sv
// tb_times_table_divider: directed and randomized self-checking bench for
// times_table_divider. Expected results come from plain integer / and %.
module tb_times_table_divider;
    localparam int unsigned N = 3;
    localparam int unsigned W = 2 * N;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    times_table_divider_if #(.N(N)) bus ();

    times_table_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One division; inj>0 pulses a competing start at that negedge after the start edge.
    task automatic run(input int a, input int b, input int inj, input string tag);
        int exp_q, exp_r, exp_e, exp_pos, exp_busy;
        int dcnt, bcnt, dpos;
        logic [31:0] q, r, e;
        if (b == 0) begin
            exp_q = 0; exp_r = 0; exp_e = 1; exp_pos = 1; exp_busy = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_e = 0; exp_pos = W + 1; exp_busy = W;
        end
        dcnt = 0; bcnt = 0; dpos = -1; q = '0; r = '0; e = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = N'(b);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = N'($urandom);
        for (int k = 1; k <= int'(W) + 4; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bcnt++;
            if (bus.done === 1'b1) begin
                dcnt++;
                if (dpos < 0) begin
                    dpos = k;
                    q = 32'(bus.quotient);
                    r = 32'(bus.remainder);
                    e = 32'(bus.err);
                end
            end
            if (inj != 0 && k == inj) begin
                bus.start    = 1'b1;
                bus.dividend = W'(10);
                bus.divisor  = N'(3);
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({tag, " done_pulses"}, 32'(dcnt), 32'd1);
        chk({tag, " done_cycle"}, 32'(dpos), 32'(exp_pos));
        chk({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        chk({tag, " quotient"}, q, 32'(exp_q));
        chk({tag, " remainder"}, r, 32'(exp_r));
        chk({tag, " err"}, e, 32'(exp_e));
        chk({tag, " quotient_hold"}, 32'(bus.quotient), 32'(exp_q));
        chk({tag, " remainder_hold"}, 32'(bus.remainder), 32'(exp_r));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " done"}, 32'(bus.done), 32'd0);
        chk({tag, " quotient"}, 32'(bus.quotient), 32'd0);
        chk({tag, " remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, " err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        int dcnt, bcnt, a, b;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(42, 6, 0, "42/6");
        run(63, 1, 0, "63/1");
        run(5, 7, 0, "5/7");
        run(0, 3, 0, "0/3");
        run(20, 0, 0, "20/0");
        run(20, 4, 0, "20/4");
        run(49, 7, 2, "49/7_ignored_start");

        // Abort mid-CALC with a short asynchronous reset pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = W'(35);
        bus.divisor = N'(5);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        rst_n = 1'b1;
        dcnt = 0; bcnt = 0;
        for (int k = 0; k < int'(W) + 3; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
            if (bus.busy === 1'b1) bcnt++;
        end
        chk("midreset no_done", 32'(dcnt), 32'd0);
        chk("midreset no_busy", 32'(bcnt), 32'd0);
        run(35, 5, 0, "35/5_after_reset");

        // Recover each factor from its product.
        for (int ai = 0; ai < 8; ai++)
            for (int bi = 1; bi < 8; bi++)
                run(ai * bi, bi, 0, "sweep_exact");

        // Products plus a nonzero remainder.
        for (int bi = 2; bi < 8; bi++)
            for (int ai = 0; ai < 8; ai++)
                for (int ri = 1; ri < bi; ri++)
                    if (ai * bi + ri <= 63)
                        run(ai * bi + ri, bi, 0, "sweep_rem");

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 63));
            b = int'($urandom_range(0, 7));
            run(a, b, 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/times_table_divider.md
Name: times_table_divider

Overview:
- Inverse of the times-table multiplier: divides a 2N-bit product by an N-bit factor and returns the quotient and remainder.
- Uses sequential restoring division, one quotient bit per clock, under a start/busy/done handshake.
- Sits downstream of the multiplier so a bench or checker can recover the original factor (e.g. 42 / 6 -> 7 r 0).

Parameters:
- N, 3, factor width; dividend and quotient are 2N bits, divisor and remainder are N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  product to divide; captured when start is accepted
- divisor  input  N  factor to divide by; captured when start is accepted
- busy  output  1  high while a division is in progress (CALC state)
- done  output  1  one-cycle pulse; quotient/remainder/err valid
- quotient  output  2N  dividend / divisor (integer)
- remainder  output  N  dividend mod divisor
- err  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset: rst_n low forces, immediately and regardless of clk:
  - state=IDLE;
  - busy=0, done=0, err=0, quotient=0, remainder=0;
  - internal count and partial remainder cleared.
- Reset mid-operation aborts the division; no done is produced.
- States are IDLE, CALC and DONE.
- IDLE:
  - start=1 at rising edge T, divisor!=0: capture operands, set working quotient=dividend, partial remainder (N+1 bits)=0, count=2N-1, clear err. Go to CALC; busy=1 from T.
  - start=1 at edge T, divisor==0: go to DONE with err=1, quotient=0, remainder=0. done=1 from T+1... precisely, done is high for the cycle after edge T (i.e. between edges T and T+1). busy is never asserted.
  - start=0: stay in IDLE.
- CALC, each edge:
  - shift {partial_rem, working_q} left by 1.
  - trial = shifted partial_rem - divisor.
  - If trial is non-negative: partial_rem=trial and quotient LSB=1; else keep the shifted partial_rem and set LSB=0.
  - Decrement count. On the edge where count==0 (the 2N-th CALC edge, T+2N), go to DONE.
- DONE (one cycle): done=1, busy=0, and quotient/remainder/err are driven with the final values. Next edge returns to IDLE.
- Latency for divisor!=0: start accepted at edge T, done high for the cycle after edge T+2N. For N=3 that is 6 cycles after the start edge.
- Outputs quotient, remainder and err hold their values after done until the next accepted start. They are not cleared on returning to IDLE.
- start is ignored while in CALC or DONE. Operands change freely during CALC without effect, since they were captured at start.
- Back-to-back: start high during the DONE cycle is ignored. A start on the first IDLE edge after DONE is accepted, giving a minimum 2N+2-cycle issue interval.
- Arithmetic is unsigned. Remainder is always < divisor. The quotient cannot overflow, because the maximum dividend of 2^(2N)-1 divided by 1 fits in 2N bits.
- No X propagation: all registers have a defined reset value.

Test Plan:
- Reset, then start with dividend=42, divisor=6 -> busy high for 6 cycles; done pulses once at start-edge+6 with quotient=7, remainder=0, err=0.
- dividend=63, divisor=1 -> quotient=63, remainder=0. Then dividend=5, divisor=7 -> quotient=0, remainder=5. Then dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=20, divisor=0 -> done one cycle after the start edge with err=1, quotient=0, remainder=0, and busy never high. A following 20 / 4 -> quotient=5, remainder=0, err=0.
- Start 49 / 7, then pulse start with 10 / 3 on cycle 2 of CALC -> second request ignored; result is quotient=7, remainder=0 and only one done pulse appears.
- Start 35 / 5, drive rst_n low for 1 ns mid-CALC (between clock edges) -> all outputs 0 immediately, no done. After release, 35 / 5 -> quotient=7, remainder=0.
- Exhaustive sweep: for every a, b in 0..7 with b!=0, divide a*b by b -> quotient=a, remainder=0. Also check (a*b+r) / b with r<b yields remainder=r where the sum is ≤63.
